jt12_kon_queue: RTL and testbench

//  Upstream feeder for the key-on shift stage. Captures CPU writes to the
//  key-on register (0x28), decodes channel/operator mask, and queues them in
//  a small FIFO so back-to-back writes are not lost while the slot sequencer
//  is still sweeping. Presents the head entry as up_keyon/keyon_ch/keyon_op

---
 rtl/jt12_kon_queue_if.sv | 24 ++
 rtl/jt12_kon_queue.sv | 93 +++++++++
 tb/tb_jt12_kon_queue.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/jt12_kon_queue_if.sv
// Key-on queue bus: CPU write strobe, slot sequencer position and queued head outputs.
// master drives writes and slot position; slave is the queue itself.
interface jt12_kon_queue_if;
   logic       clk_en;
   logic       wr_keyon;
   logic [7:0] din;
   logic [1:0] next_op;
   logic [2:0] next_ch;
   logic       up_keyon;
   logic [2:0] keyon_ch;
   logic [3:0] keyon_op;
   logic       q_full;
   logic       q_lost;

   modport master (
      output clk_en, wr_keyon, din, next_op, next_ch,
      input  up_keyon, keyon_ch, keyon_op, q_full, q_lost
   );

   modport slave (
      input  clk_en, wr_keyon, din, next_op, next_ch,
      output up_keyon, keyon_ch, keyon_op, q_full, q_lost
   );
endinterface

// File: rtl/jt12_kon_queue.sv
// Queues CPU key-on register writes and presents the oldest one to the key-on
// stage until the slot sequencer reaches that channel's operator-3 slot.
module jt12_kon_queue #(
   parameter int num_ch = 6,
   parameter int DEPTH  = 4,
   parameter int AW     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   jt12_kon_queue_if.slave  kon
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [6:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          up_keyon_q, up_keyon_d;
   logic [2:0]    keyon_ch_q, keyon_ch_d;
   logic [3:0]    keyon_op_q, keyon_op_d;
   logic          lost_q, lost_d;

   logic          code_ok;
   logic          full;
   logic          retire;
   logic          push;
   logic [6:0]    new_entry;
   logic          unused_din3;

   assign unused_din3 = kon.din[3];
   assign new_entry   = {kon.din[2:0], kon.din[7:4]};

   always_comb begin
      code_ok = (kon.din[2:0] != 3'd3) && (kon.din[2:0] != 3'd7);
      if (num_ch == 3 && kon.din[2])
         code_ok = 1'b0;

      full   = (cnt_q == FULL_CNT);
      // The registered head is the entry the key-on stage samples on this edge
      retire = kon.clk_en && up_keyon_q && (kon.next_ch == keyon_ch_q) &&
               (kon.next_op == 2'd3);
      push   = kon.wr_keyon && code_ok && (!full || retire);
      lost_d = lost_q | (kon.wr_keyon && code_ok && full && !retire);

      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(retire);
      cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(retire);

      up_keyon_d = (cnt_d != '0);
      keyon_ch_d = keyon_ch_q;
      keyon_op_d = keyon_op_q;
      if (cnt_d != '0) begin
         // Queue drains to nothing this edge, so the new head is the incoming write
         if (push && (cnt_q == (AW+1)'(retire)))
            {keyon_ch_d, keyon_op_d} = new_entry;
         else
            {keyon_ch_d, keyon_op_d} = mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         up_keyon_q <= 1'b0;
         keyon_ch_q <= 3'd0;
         keyon_op_q <= 4'd0;
         lost_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         up_keyon_q <= up_keyon_d;
         keyon_ch_q <= keyon_ch_d;
         keyon_op_q <= keyon_op_d;
         lost_q     <= lost_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= new_entry;
   end

   assign kon.up_keyon = up_keyon_q;
   assign kon.keyon_ch = keyon_ch_q;
   assign kon.keyon_op = keyon_op_q;
   assign kon.q_full   = full;
   assign kon.q_lost   = lost_q;

endmodule

// File: tb/tb_jt12_kon_queue.sv
// Bench for jt12_kon_queue: a 6-channel and a 3-channel instance share stimulus and
// are compared every cycle against an ordered-list model of the key-on queue.
module tb_jt12_kon_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   jt12_kon_queue_if if6();
   jt12_kon_queue_if if3();

   jt12_kon_queue #(.num_ch(6), .DEPTH(DEPTH), .AW(2)) u6 (
      .clk(clk), .rst_n(rst_n), .kon(if6.slave));
   jt12_kon_queue #(.num_ch(3), .DEPTH(DEPTH), .AW(2)) u3 (
      .clk(clk), .rst_n(rst_n), .kon(if3.slave));

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Model: per instance an ordered list of {ch,op}, sticky lost flag, last head shown
   logic [6:0] mq [2][16];
   int         mn [2];
   bit         mlost [2];
   logic [2:0] mch [2];
   logic [3:0] mop [2];

   logic [2:0] chtab [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         mn[k] = 0; mlost[k] = 1'b0; mch[k] = 3'd0; mop[k] = 4'd0;
      end
   endtask

   task automatic model_step(input int k, input bit en, input bit wr, input logic [7:0] d,
                             input logic [2:0] nc, input logic [1:0] no);
      int  nch;
      bit  valid, full, ret;
      nch   = (k == 0) ? 6 : 3;
      valid = wr && d[2:0] != 3'd3 && d[2:0] != 3'd7 && !(nch == 3 && d[2:0] >= 3'd4);
      full  = (mn[k] == DEPTH);
      ret   = en && mn[k] > 0 && no == 2'd3 && nc == mq[k][0][6:4];
      if (ret) begin
         for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
         mn[k]--;
      end
      if (valid) begin
         if (!full || ret) begin
            mq[k][mn[k]] = {d[2:0], d[7:4]};
            mn[k]++;
         end else
            mlost[k] = 1'b1;
      end
      if (mn[k] > 0) {mch[k], mop[k]} = mq[k][0];
   endtask

   task automatic set_in(input bit en, input bit wr, input logic [7:0] d,
                         input logic [2:0] nc, input logic [1:0] no);
      if6.clk_en = en; if6.wr_keyon = wr; if6.din = d; if6.next_ch = nc; if6.next_op = no;
      if3.clk_en = en; if3.wr_keyon = wr; if3.din = d; if3.next_ch = nc; if3.next_op = no;
   endtask

   // One clock: inputs applied at negedge, model advanced to post-edge state
   task automatic cyc(input bit en, input bit wr, input logic [7:0] d,
                      input logic [2:0] nc, input logic [1:0] no);
      @(negedge clk);
      set_in(en, wr, d, nc, no);
      model_step(0, en, wr, d, nc, no);
      model_step(1, en, wr, d, nc, no);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input bit chk_async);
      @(negedge clk);
      set_in(1'b0, 1'b0, 8'h00, 3'd0, 2'd0);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      if (chk_async) begin
         chk("async_rst_up6", int'(if6.up_keyon), 0);
         chk("async_rst_up3", int'(if3.up_keyon), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic mon_one(input int k, input logic up, input logic [2:0] ch,
                          input logic [3:0] op, input logic full, input logic lost);
      string s;
      s = (k == 0) ? "6" : "3";
      chk({"mon_up", s}, int'(up), int'(mn[k] > 0));
      chk({"mon_ch", s}, int'(ch), int'(mch[k]));
      chk({"mon_op", s}, int'(op), int'(mop[k]));
      chk({"mon_full", s}, int'(full), int'(mn[k] == DEPTH));
      chk({"mon_lost", s}, int'(lost), int'(mlost[k]));
   endtask

   always @(posedge clk) begin
      #2;
      if (mon_en) begin
         mon_one(0, if6.up_keyon, if6.keyon_ch, if6.keyon_op, if6.q_full, if6.q_lost);
         mon_one(1, if3.up_keyon, if3.keyon_ch, if3.keyon_op, if3.q_full, if3.q_lost);
      end
   end

   // Sweep every channel/op slot once with clk_en high
   task automatic sweep(input int n);
      for (int s = 0; s < n; s++)
         cyc(1'b1, 1'b0, 8'h00, chtab[s % 6], 2'((s / 6) % 4));
   endtask

   initial begin
      int slot;
      set_in(1'b0, 1'b0, 8'h00, 3'd0, 2'd0);
      model_clear();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #2;
      chk("rst_up", int'(if6.up_keyon), 0);
      chk("rst_ch", int'(if6.keyon_ch), 0);
      chk("rst_op", int'(if6.keyon_op), 0);
      chk("rst_full", int'(if6.q_full), 0);
      chk("rst_lost", int'(if6.q_lost), 0);

      // single write, held until ch1/op3 with clk_en
      cyc(1'b0, 1'b1, 8'hF1, 3'd0, 2'd0);
      chk("t1_up", int'(if6.up_keyon), 1);
      chk("t1_ch", int'(if6.keyon_ch), 1);
      chk("t1_op", int'(if6.keyon_op), 15);
      cyc(1'b1, 1'b0, 8'h00, 3'd1, 2'd2);
      chk("t1_hold_op2", int'(if6.up_keyon), 1);
      cyc(1'b0, 1'b0, 8'h00, 3'd1, 2'd3);
      chk("t1_hold_noen", int'(if6.up_keyon), 1);
      cyc(1'b1, 1'b0, 8'h00, 3'd1, 2'd3);
      chk("t1_retired6", int'(if6.up_keyon), 0);
      chk("t1_retired3", int'(if3.up_keyon), 0);
      chk("t1_hold_ch", int'(if6.keyon_ch), 1);

      // invalid codes
      cyc(1'b0, 1'b1, 8'h13, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h07, 3'd0, 2'd0);
      chk("t2_inv_up", int'(if6.up_keyon), 0);
      chk("t2_inv_lost", int'(if6.q_lost), 0);
      cyc(1'b0, 1'b1, 8'h14, 3'd0, 2'd0);
      chk("t2_ch4_up6", int'(if6.up_keyon), 1);
      chk("t2_ch4_up3", int'(if3.up_keyon), 0);
      do_reset(1'b0);

      // ordered presentation 0,4,2
      cyc(1'b0, 1'b1, 8'h10, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h24, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h32, 3'd0, 2'd0);
      chk("t3_head_ch", int'(if6.keyon_ch), 0);
      sweep(24 * 3);
      chk("t3_drained6", int'(if6.up_keyon), 0);
      chk("t3_drained3", int'(if3.up_keyon), 0);
      chk("t3_nolost", int'(if6.q_lost), 0);
      do_reset(1'b0);

      // overflow without retire
      for (int i = 0; i < DEPTH + 1; i++) begin
         cyc(1'b0, 1'b1, {4'(i + 1), 4'h1}, 3'd0, 2'd0);
         if (i == DEPTH - 1) begin
            chk("t4_full", int'(if6.q_full), 1);
            chk("t4_notlost", int'(if6.q_lost), 0);
         end
      end
      chk("t4_lost", int'(if6.q_lost), 1);
      chk("t4_head_op", int'(if6.keyon_op), 1);
      do_reset(1'b0);

      // full FIFO, write on the retire edge
      cyc(1'b0, 1'b1, 8'h50, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h61, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h72, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h80, 3'd0, 2'd0);
      cyc(1'b1, 1'b1, 8'hA2, 3'd0, 2'd3);
      chk("t5_full", int'(if6.q_full), 1);
      chk("t5_lost", int'(if6.q_lost), 0);
      chk("t5_head_ch", int'(if6.keyon_ch), 1);
      chk("t5_head_op", int'(if6.keyon_op), 6);

      // async reset with entries queued
      do_reset(1'b0);
      cyc(1'b0, 1'b1, 8'h11, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h22, 3'd0, 2'd0);
      cyc(1'b0, 1'b1, 8'h30, 3'd0, 2'd0);
      do_reset(1'b1);
      @(posedge clk); #2;
      chk("t6_up", int'(if6.up_keyon), 0);
      chk("t6_ch", int'(if6.keyon_ch), 0);
      chk("t6_op", int'(if6.keyon_op), 0);

      // randomized traffic against a sweeping slot sequencer
      slot = 0;
      for (int n = 0; n < 3000; n++) begin
         bit en, wr;
         logic [7:0] d;
         en = ($urandom % 4) != 0;
         wr = ($urandom % 10) == 0;
         d  = 8'($urandom);
         cyc(en, wr, d, chtab[slot % 6], 2'(slot / 6));
         if (en) slot = (slot + 1) % 24;
         if (n % 600 == 599) do_reset(1'b1);
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
